mandel_iter_ctrl: RTL and testbench
===================================

// Module: mandel_iter_ctrl
// PURPOSE
//  Iteration scheduler wrapped around the fixed-latency Mandelbrot core (z <- z^2 + c).
//  - Accepts pixels (c = x0 + j*y0, plus a tag) from the pixel generator.
//  - Keeps up to LATENCY pixels in flight, one per pipeline slot.
//  - Feeds each core result back as the next z, and tests for escape.
//  - Retires each finished pixel with its iteration count to the colour/framebuffer stage.
// PARAMETERS
//  LATENCY  19   core input->output latency in cycles; equals the number of ring slots
//  MAXITER  255  iteration cap; a pixel retires non-escaped once it completes this many passes
//  TAGW     16   pixel tag width (framebuffer address)
//  ITW      8    iteration count width; must satisfy MAXITER < 2**ITW
// PORTS
//  clock       in   1     system clock
//  rst_n       in   1     asynchronous active-low reset
//  in_valid    in   1     new pixel offered
//  in_ready    out  1     new pixel accepted this cycle when in_valid&in_ready
//  in_x0       in   32    IEEE-754 single, real part of c
//  in_y0       in   32    IEEE-754 single, imaginary part of c
//  in_tag      in   TAGW  pixel identifier
//  core_x0     out  32    to core x0
//  core_y0     out  32    to core y0
//  core_xn     out  32    to core xn
//  core_yn     out  32    to core yn
//  core_xn1    in   32    from core: result for inputs presented LATENCY cycles earlier
//  core_yn1    in   32    from core: result for inputs presented LATENCY cycles earlier
//  out_valid   out  1     retired pixel available
//  out_ready   in   1     downstream accepts when out_valid&out_ready
//  out_tag     out  TAGW  tag of retired pixel
//  out_iter    out  ITW   number of core passes completed, 1..MAXITER
//  out_escaped out  1     1 = escaped, 0 = hit MAXITER
// BEHAVIOUR
//  Shadow ring:
//  - LATENCY-deep shift register of {valid, done, esc, iter, tag, x0, y0}.
//  - Advances every cycle; never stalls, because the core has no enable.
//  - Entry leaving the ring each cycle = "emerging slot"; it aligns with core_xn1/core_yn1.
//  Escape test on emerging core_xn1/yn1:
//  - esc_now = (exp[30:23] >= 8'd128) on either value, i.e. |x|>=2.0, |y|>=2.0, Inf or NaN.
//  - Box test; implies |z| >= 2.
//  Per cycle, for the emerging slot S (iter' = S.iter+1 if !S.done, else S.iter):
//  - S invalid -> slot free.
//  - S.done=0, esc_now or iter'==MAXITER -> finished.
//  - S.done=0, otherwise -> recirculate: core_xn/yn = core_xn1/yn1, core_x0/y0 = S.x0/y0, iter=iter'.
//  - S.done=1 -> finished, using the stored esc/iter; core results are ignored.
//  out_free = !out_valid | out_ready.
//  - Finished & out_free -> load output register {tag, iter', esc}; slot becomes free.
//  - Finished & !out_free -> recirculate with done=1 and esc/iter frozen; retry LATENCY cycles later.
//  in_ready = slot free this cycle (combinational from ring state, out_valid, out_ready).
//  On accept, inject into the tail slot:
//  - core_xn = core_yn = 0; core_x0/y0 = in_x0/y0; iter=0, done=0, valid=1.
//  - First result is therefore z1 = c.
//  Recirculation has absolute priority over new pixels; new pixels never displace in-flight ones.
//  When neither recirculating nor injecting: tail slot valid=0, all core inputs driven 0.
//  Output register: holds out_* stable while out_valid & !out_ready; clears out_valid on handshake
//   unless reloaded the same cycle (back-to-back retire allowed).
//  Ordering: retirement order follows escape time, not input order; tags identify pixels.
//  Ring full (all LATENCY slots busy recirculating): in_ready=0 until a slot retires.
//  Reset (async, any time): all slot valid bits 0; in-flight pixels dropped.
//  - out_valid=0; out_tag/out_iter/out_escaped=0; core_* = 0.
//  - in_ready may rise on the first cycle after release.
//  Latency: pixel escaping after k passes appears on out_valid k*LATENCY+1 cycles after accept
//   (no backpressure).
// TESTING
//  1 c=(0,0) single pixel, out_ready=1 -> out_iter=255, out_escaped=0, at 255*19+1 cycles.
//  2 in_x0=0x40400000 (3.0), y0=0 -> out_iter=1, out_escaped=1, out_valid at accept+20.
//  3 c=(-1.0,0) -> cycles 0/-1 -> MAXITER non-escaped; c=(0.5,0.5) -> escapes at iter=5.
//  4 Two 1-pass escapers back-to-back, out_ready=0 for 30 cycles ->
//    first is held in the output register; second recirculates with done=1;
//    both are delivered with iter=1 and esc=1, and no pixel is lost.
//  5 in_valid held high with 25 c=(0,0) pixels -> exactly 19 accepted, then in_ready=0
//    until the first retires.
//  6 Assert rst_n low mid-run with 10 pixels in flight -> outputs 0 immediately;
//    after release, no stale pixel ever appears on out_valid.

Source files
------------

// File: rtl/mandel_iter_ctrl_if.sv
// mandel_iter_ctrl_if
//   Bundle of every handshake and data signal between the iteration
//   scheduler and its neighbours: the pixel generator (in_*), the
//   fixed-latency Mandelbrot core (core_*) and the colour/framebuffer
//   stage (out_*).
//   modport slave  : scheduler view (drives in_ready, core operands, out_*)
//   modport master : environment view (drives pixels, core results, out_ready)
interface mandel_iter_ctrl_if #(
    parameter int TAGW = 16,
    parameter int ITW  = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_x0;
    logic [31:0]     in_y0;
    logic [TAGW-1:0] in_tag;

    logic [31:0]     core_x0;
    logic [31:0]     core_y0;
    logic [31:0]     core_xn;
    logic [31:0]     core_yn;
    logic [31:0]     core_xn1;
    logic [31:0]     core_yn1;

    logic            out_valid;
    logic            out_ready;
    logic [TAGW-1:0] out_tag;
    logic [ITW-1:0]  out_iter;
    logic            out_escaped;

    modport slave (
        input  in_valid, in_x0, in_y0, in_tag, core_xn1, core_yn1, out_ready,
        output in_ready, core_x0, core_y0, core_xn, core_yn,
               out_valid, out_tag, out_iter, out_escaped
    );

    modport master (
        output in_valid, in_x0, in_y0, in_tag, core_xn1, core_yn1, out_ready,
        input  in_ready, core_x0, core_y0, core_xn, core_yn,
               out_valid, out_tag, out_iter, out_escaped
    );
endinterface

// File: rtl/mandel_iter_ctrl.sv
// mandel_iter_ctrl
//   Iteration scheduler around a fixed-latency Mandelbrot core (z <- z^2 + c).
//   A LATENCY-deep shadow ring tracks which pixel occupies each core
//   pipeline slot. Each cycle the slot leaving the ring lines up with the
//   core result; the pixel is either recirculated for another pass or
//   retired with its iteration count. Free slots accept new pixels.
// Ports
//   clock  : system clock
//   rst_n  : asynchronous active-low reset, drops every in-flight pixel
//   bus    : mandel_iter_ctrl_if.slave
//            in_*   pixel stream from the pixel generator (valid/ready)
//            core_* operands to / results from the core (no enable)
//            out_*  retired pixel {tag, iter, escaped} (valid/ready)
module mandel_iter_ctrl #(
    parameter int LATENCY = 19,
    parameter int MAXITER = 255,
    parameter int TAGW    = 16,
    parameter int ITW     = 8
) (
    input  logic                   clock,
    input  logic                   rst_n,
    mandel_iter_ctrl_if.slave      bus
);

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            esc;
        logic [ITW-1:0]  iter;
        logic [TAGW-1:0] tag;
        logic [31:0]     x0;
        logic [31:0]     y0;
    } slot_t;

    slot_t ring [LATENCY];
    slot_t emerge;
    slot_t tail;

    logic            run_q;
    logic            out_valid_q;
    logic [TAGW-1:0] out_tag_q;
    logic [ITW-1:0]  out_iter_q;
    logic            out_esc_q;

    logic            esc_now;
    logic [ITW-1:0]  iter_next;
    logic            esc_final;
    logic            finished;
    logic            out_free;
    logic            retire;
    logic            recirc;
    logic            in_ready_c;
    logic            inject;
    logic [31:0]     core_x0_c;
    logic [31:0]     core_y0_c;
    logic [31:0]     core_xn_c;
    logic [31:0]     core_yn_c;

    // Exponent >= 128 means |v| >= 2.0, Inf or NaN.
    always_comb begin
        emerge    = ring[LATENCY-1];
        esc_now   = (bus.core_xn1[30:23] >= 8'd128) || (bus.core_yn1[30:23] >= 8'd128);
        iter_next = emerge.done ? emerge.iter : emerge.iter + ITW'(1);
        esc_final = emerge.done ? emerge.esc : esc_now;
        finished  = emerge.valid && (emerge.done || esc_now || (iter_next == ITW'(MAXITER)));
        out_free  = !out_valid_q || bus.out_ready;
        retire    = finished && out_free;
        recirc    = emerge.valid && !retire;
        // run_q keeps the input closed while reset is asserted, so the core
        // bus stays at zero until the first clock after release.
        in_ready_c = run_q && !recirc;
        inject     = bus.in_valid && in_ready_c;
    end

    // Core operands are driven combinationally: the ring is exactly as deep
    // as the core latency, so operands must reach the core in the same cycle
    // their bookkeeping enters the tail slot.
    always_comb begin
        tail      = '0;
        core_x0_c = '0;
        core_y0_c = '0;
        core_xn_c = '0;
        core_yn_c = '0;
        if (recirc) begin
            tail       = emerge;
            tail.done  = finished;
            tail.esc   = esc_final;
            tail.iter  = iter_next;
            core_x0_c  = emerge.x0;
            core_y0_c  = emerge.y0;
            core_xn_c  = bus.core_xn1;
            core_yn_c  = bus.core_yn1;
        end else if (inject) begin
            tail.valid = 1'b1;
            tail.tag   = bus.in_tag;
            tail.x0    = bus.in_x0;
            tail.y0    = bus.in_y0;
            core_x0_c  = bus.in_x0;
            core_y0_c  = bus.in_y0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                ring[i] <= '0;
            end
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_iter_q  <= '0;
            out_esc_q   <= 1'b0;
        end else begin
            ring[0] <= tail;
            for (int i = 1; i < LATENCY; i++) begin
                ring[i] <= ring[i-1];
            end
            run_q <= 1'b1;
            if (retire) begin
                out_valid_q <= 1'b1;
                out_tag_q   <= emerge.tag;
                out_iter_q  <= iter_next;
                out_esc_q   <= esc_final;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.core_x0     = core_x0_c;
    assign bus.core_y0     = core_y0_c;
    assign bus.core_xn     = core_xn_c;
    assign bus.core_yn     = core_yn_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_iter    = out_iter_q;
    assign bus.out_escaped = out_esc_q;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
module tb_mandel_iter_ctrl;
    localparam int LAT  = 19;
    localparam int MAXI = 255;
    localparam int TAGW = 16;
    localparam int ITW  = 8;

    localparam logic [31:0] F_ZERO  = 32'h00000000;
    localparam logic [31:0] F_THREE = 32'h40400000;
    localparam logic [31:0] F_M_ONE = 32'hBF800000;
    localparam logic [31:0] F_HALF  = 32'h3F000000;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rnd_bp = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mandel_iter_ctrl_if #(.TAGW(TAGW), .ITW(ITW)) bus ();

    mandel_iter_ctrl #(.LATENCY(LAT), .MAXITER(MAXI), .TAGW(TAGW), .ITW(ITW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---- single-precision helpers (truncating, flush-to-zero) ----
    function automatic real s2d(input logic [31:0] f);
        logic [63:0] b;
        logic [10:0] e;
        if (f[30:23] == 8'd0) b = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) b = {f[31], 11'h7FF, f[22:0], 29'd0};
        else begin
            e = 11'(f[30:23]) + 11'd896;
            b = {f[31], e, f[22:0], 29'd0};
        end
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] d2s(input real r);
        logic [63:0] b;
        int e;
        b = $realtobits(r);
        e = int'(b[62:52]);
        if (e == 0) return {b[63], 31'd0};
        if (e == 2047) return {b[63], 8'hFF, (b[51:0] != 0) ? 23'h400000 : 23'd0};
        e = e - 896;
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        if (e <= 0) return {b[63], 31'd0};
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [63:0] mstep(input logic [31:0] x0, y0, xn, yn);
        real a, b, cx, cy;
        a = s2d(xn); b = s2d(yn); cx = s2d(x0); cy = s2d(y0);
        return {d2s(a * a - b * b + cx), d2s(2.0 * a * b + cy)};
    endfunction

    // Reference: iterate z from 0 until |x| or |y| reaches 2 (or non-finite).
    function automatic void ref_pixel(input logic [31:0] x0, y0, output int it, output bit esc);
        logic [31:0] zx, zy;
        logic [63:0] r;
        real vx, vy;
        zx = 32'd0; zy = 32'd0;
        it = MAXI; esc = 1'b0;
        for (int n = 1; n <= MAXI; n++) begin
            r = mstep(x0, y0, zx, zy);
            zx = r[63:32]; zy = r[31:0];
            vx = s2d(zx); vy = s2d(zy);
            if (!(vx < 2.0 && vx > -2.0) || !(vy < 2.0 && vy > -2.0)) begin
                it = n; esc = 1'b1;
                break;
            end
        end
    endfunction

    // ---- core model: fixed LAT-cycle pipeline, no enable ----
    logic [63:0] core_pipe [LAT];
    always @(posedge clock) begin
        for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= mstep(bus.core_x0, bus.core_y0, bus.core_xn, bus.core_yn);
    end
    assign bus.core_xn1 = core_pipe[LAT-1][63:32];
    assign bus.core_yn1 = core_pipe[LAT-1][31:0];

    // ---- retirement collector ----
    typedef struct {
        int tag;
        int iter;
        bit esc;
        int cyc;
    } ret_t;
    ret_t ret_q[$];

    int exp_iter[int];
    bit exp_esc[int];
    int acc_cyc[int];

    always @(negedge clock) begin
        #1;
        if (rst_n && bus.out_valid && bus.out_ready)
            ret_q.push_back('{int'(bus.out_tag), int'(bus.out_iter), bus.out_escaped, cyc});
    end

    always @(negedge clock) begin
        if (rnd_bp) bus.out_ready = ($urandom_range(0, 9) < 6);
    end

    // Holds one pixel on the input until accepted; records its expectation.
    task automatic offer(input logic [31:0] x0, y0, input int tag, output bit ok);
        int it;
        bit e;
        ok = 1'b0;
        for (int k = 0; k < 6000 && !ok; k++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.in_x0 = x0;
            bus.in_y0 = y0;
            bus.in_tag = TAGW'(tag);
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                acc_cyc[tag] = cyc + 1;
                ref_pixel(x0, y0, it, e);
                exp_iter[tag] = it;
                exp_esc[tag] = e;
            end
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_retired(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (ret_q.size() < n && k < budget) begin
            @(negedge clock);
            #2;
            k++;
        end
        ok = (ret_q.size() >= n);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_tag !== '0 || bus.out_iter !== '0 || bus.out_escaped !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got v=%0b tag=%0d iter=%0d esc=%0b required all 0",
                     bus.out_valid, bus.out_tag, bus.out_iter, bus.out_escaped);
        end
        checks++;
        if ({bus.core_x0, bus.core_y0, bus.core_xn, bus.core_yn} !== 128'd0) begin
            failures++;
            $display("FAIL reset_core: got %h %h %h %h required 0", bus.core_x0, bus.core_y0, bus.core_xn, bus.core_yn);
        end
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
        end
    endtask

    task automatic test_single_zero();
        bit ok;
        ret_q.delete();
        offer(F_ZERO, F_ZERO, 1, ok);
        wait_retired(1, MAXI * LAT + 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL zero_timeout: retired=%0d required 1", ret_q.size());
        end else begin
            checks++;
            if (ret_q[0].tag !== 1 || ret_q[0].iter !== 255 || ret_q[0].esc !== 1'b0) begin
                failures++;
                $display("FAIL zero_result: got tag=%0d iter=%0d esc=%0b required tag=1 iter=255 esc=0",
                         ret_q[0].tag, ret_q[0].iter, ret_q[0].esc);
            end
            // Edge-count from accept edge to output-register load edge.
            checks++;
            if (ret_q[0].cyc - acc_cyc[1] !== 255 * LAT) begin
                failures++;
                $display("FAIL zero_latency: got %0d required %0d", ret_q[0].cyc - acc_cyc[1], 255 * LAT);
            end
        end
    endtask

    task automatic test_fast_escape();
        bit ok;
        ret_q.delete();
        offer(F_THREE, F_ZERO, 2, ok);
        wait_retired(1, 3 * LAT, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL esc1_timeout: retired=%0d required 1", ret_q.size());
        end else begin
            checks++;
            if (ret_q[0].tag !== 2 || ret_q[0].iter !== 1 || ret_q[0].esc !== 1'b1) begin
                failures++;
                $display("FAIL esc1_result: got tag=%0d iter=%0d esc=%0b required tag=2 iter=1 esc=1",
                         ret_q[0].tag, ret_q[0].iter, ret_q[0].esc);
            end
            checks++;
            if (ret_q[0].cyc - acc_cyc[2] !== LAT) begin
                failures++;
                $display("FAIL esc1_latency: got %0d required %0d", ret_q[0].cyc - acc_cyc[2], LAT);
            end
        end
    endtask

    task automatic test_known_points();
        bit ok;
        ret_q.delete();
        offer(F_M_ONE, F_ZERO, 3, ok);
        offer(F_HALF, F_HALF, 4, ok);
        wait_retired(2, MAXI * LAT + 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL known_timeout: retired=%0d required 2", ret_q.size());
        end else begin
            // Escape-time ordering: the 5-pass pixel leaves first.
            checks++;
            if (ret_q[0].tag !== 4 || ret_q[0].iter !== 5 || ret_q[0].esc !== 1'b1) begin
                failures++;
                $display("FAIL known_half: got tag=%0d iter=%0d esc=%0b required tag=4 iter=5 esc=1",
                         ret_q[0].tag, ret_q[0].iter, ret_q[0].esc);
            end
            checks++;
            if (ret_q[1].tag !== 3 || ret_q[1].iter !== 255 || ret_q[1].esc !== 1'b0) begin
                failures++;
                $display("FAIL known_m1: got tag=%0d iter=%0d esc=%0b required tag=3 iter=255 esc=0",
                         ret_q[1].tag, ret_q[1].iter, ret_q[1].esc);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, seen, bad;
        ret_q.delete();
        @(negedge clock);
        bus.out_ready = 1'b0;
        offer(F_THREE, F_ZERO, 10, ok);
        offer(F_THREE, F_ZERO, 11, ok);
        seen = 1'b0; bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                if (bus.out_tag !== TAGW'(10) || bus.out_iter !== ITW'(1) || bus.out_escaped !== 1'b1) bad = 1'b1;
            end else if (seen) bad = 1'b1;
        end
        checks++;
        if (!seen || bad) begin
            failures++;
            $display("FAIL bp_hold: got seen=%0b unstable=%0b required seen=1 unstable=0", seen, bad);
        end
        @(negedge clock);
        bus.out_ready = 1'b1;
        wait_retired(2, 3 * LAT, ok);
        repeat (2 * LAT) @(negedge clock);
        checks++;
        if (ret_q.size() !== 2) begin
            failures++;
            $display("FAIL bp_count: got %0d required 2", ret_q.size());
        end else begin
            checks++;
            if (ret_q[0].tag !== 10 || ret_q[1].tag !== 11 || ret_q[0].iter !== 1 || ret_q[1].iter !== 1
                || ret_q[0].esc !== 1'b1 || ret_q[1].esc !== 1'b1) begin
                failures++;
                $display("FAIL bp_result: got tags=%0d,%0d iters=%0d,%0d esc=%0b,%0b required 10,11 1,1 1,1",
                         ret_q[0].tag, ret_q[1].tag, ret_q[0].iter, ret_q[1].iter, ret_q[0].esc, ret_q[1].esc);
            end
        end
    endtask

    task automatic test_ring_full();
        int idx, n_first, it, t;
        bit e, ok, low_after;
        ret_q.delete();
        idx = 0;
        low_after = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.in_x0 = F_ZERO; bus.in_y0 = F_ZERO;
            bus.in_tag = TAGW'(100 + idx);
            #1;
            if (bus.in_ready) begin
                acc_cyc[100 + idx] = cyc + 1;
                ref_pixel(F_ZERO, F_ZERO, it, e);
                exp_iter[100 + idx] = it; exp_esc[100 + idx] = e;
                idx++;
            end
            if (k > 30 && bus.in_ready) low_after = 1'b0;
        end
        n_first = idx;
        checks++;
        if (n_first !== LAT || !low_after) begin
            failures++;
            $display("FAIL full_accept: got accepted=%0d ready_low=%0b required %0d and 1", n_first, low_after, LAT);
        end
        for (int k = 0; k < 6000 && idx < 25; k++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.in_tag = TAGW'(100 + idx);
            #1;
            if (bus.in_ready) begin
                acc_cyc[100 + idx] = cyc + 1;
                ref_pixel(F_ZERO, F_ZERO, it, e);
                exp_iter[100 + idx] = it; exp_esc[100 + idx] = e;
                idx++;
            end
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (idx !== 25) begin
            failures++;
            $display("FAIL full_total: got accepted=%0d required 25", idx);
        end else begin
            checks++;
            if (acc_cyc[100 + LAT] - acc_cyc[100] !== MAXI * LAT) begin
                failures++;
                $display("FAIL full_reopen: got %0d required %0d", acc_cyc[100 + LAT] - acc_cyc[100], MAXI * LAT);
            end
        end
        wait_retired(25, MAXI * LAT + 200, ok);
        checks++;
        if (ret_q.size() !== 25) begin
            failures++;
            $display("FAIL full_retired: got %0d required 25", ret_q.size());
        end
        for (int i = 0; i < ret_q.size(); i++) begin
            t = ret_q[i].tag;
            checks++;
            if (!exp_iter.exists(t) || ret_q[i].iter !== exp_iter[t] || ret_q[i].esc !== exp_esc[t]) begin
                failures++;
                $display("FAIL full_pixel: got tag=%0d iter=%0d esc=%0b required a pending tag with iter=255 esc=0",
                         t, ret_q[i].iter, ret_q[i].esc);
            end
            if (exp_iter.exists(t)) exp_iter.delete(t);
        end
    endtask

    task automatic test_random();
        bit ok;
        int t, bad;
        real rx, ry;
        ret_q.delete();
        exp_iter.delete();
        exp_esc.delete();
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rx = -2.0 + real'($urandom_range(0, 3000)) / 1000.0;
            ry = -1.5 + real'($urandom_range(0, 3000)) / 1000.0;
            offer(d2s(rx), d2s(ry), 400 + i, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rnd_accept: got accepted=0 required 1 for tag %0d", 400 + i);
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_retired(40, 20000, ok);
        rnd_bp = 1'b0;
        @(negedge clock);
        bus.out_ready = 1'b1;
        checks++;
        if (ret_q.size() !== 40) begin
            failures++;
            $display("FAIL rnd_count: got %0d required 40", ret_q.size());
        end
        bad = 0;
        for (int i = 0; i < ret_q.size(); i++) begin
            t = ret_q[i].tag;
            checks++;
            if (!exp_iter.exists(t) || ret_q[i].iter !== exp_iter[t] || ret_q[i].esc !== exp_esc[t]) begin
                failures++;
                $display("FAIL rnd_pixel: got tag=%0d iter=%0d esc=%0b required iter=%0d esc=%0b",
                         t, ret_q[i].iter, ret_q[i].esc,
                         exp_iter.exists(t) ? exp_iter[t] : -1, exp_esc.exists(t) ? exp_esc[t] : 1'b0);
            end
            if (exp_iter.exists(t)) exp_iter.delete(t);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        ret_q.delete();
        @(negedge clock);
        bus.out_ready = 1'b0;
        offer(F_THREE, F_ZERO, 199, ok);
        for (int i = 0; i < 10; i++) offer(F_ZERO, F_ZERO, 200 + i, ok);
        repeat (30) @(negedge clock);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: got out_valid=%0b required 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_tag !== '0 || bus.out_iter !== '0 || bus.out_escaped !== 1'b0) begin
            failures++;
            $display("FAIL midrst_out: got v=%0b tag=%0d iter=%0d esc=%0b required all 0",
                     bus.out_valid, bus.out_tag, bus.out_iter, bus.out_escaped);
        end
        checks++;
        if ({bus.core_x0, bus.core_y0, bus.core_xn, bus.core_yn} !== 128'd0) begin
            failures++;
            $display("FAIL midrst_core: got %h %h %h %h required 0", bus.core_x0, bus.core_y0, bus.core_xn, bus.core_yn);
        end
        repeat (3) @(negedge clock);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        ret_q.delete();
        repeat (MAXI * LAT + 50) @(negedge clock);
        #2;
        checks++;
        if (ret_q.size() !== 0) begin
            failures++;
            $display("FAIL midrst_stale: got %0d retired required 0 (first tag %0d)", ret_q.size(), ret_q[0].tag);
        end
        ret_q.delete();
        offer(F_THREE, F_ZERO, 300, ok);
        wait_retired(1, 3 * LAT, ok);
        checks++;
        if (!ok || ret_q[0].tag !== 300 || ret_q[0].iter !== 1 || ret_q[0].esc !== 1'b1) begin
            failures++;
            $display("FAIL midrst_resume: got retired=%0d required tag 300 iter 1 esc 1", ret_q.size());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_x0 = '0;
        bus.in_y0 = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_zero();
        test_fast_escape();
        test_known_points();
        test_back_to_back();
        test_ring_full();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
